// File: rtl/ysyx_22041752_div_if.sv
// Request/response bundle between the EXE stage and the iterative divider.
// EXE drives the request side and the flush; the divider returns result, out_valid and busy.
interface ysyx_22041752_div_if #(
  parameter int WIDTH = 64
);
  logic             flush;
  logic             div_valid;
  logic             div_u;
  logic             div_w;
  logic             div_rem;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             busy;

  modport master (
    output flush, div_valid, div_u, div_w, div_rem, dividend, divisor,
    input  result, out_valid, busy
  );

  modport slave (
    input  flush, div_valid, div_u, div_w, div_rem, dividend, divisor,
    output result, out_valid, busy
  );
endinterface

// File: rtl/ysyx_22041752_div.sv
// Radix-2 restoring divider for RV64M DIV/REM families, one quotient bit per cycle.
// Done pulse in cycle N+1 after acceptance (N=64, or 32 for word ops); divide-by-zero/overflow in cycle 1.
module ysyx_22041752_div #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  ysyx_22041752_div_if.slave   io
);
  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             is_rem_q, is_rem_d;
  logic             is_w_q, is_w_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  // Operand conditioning: word ops use the low half, extended per signedness.
  logic [WIDTH-1:0] a_sw, b_sw, a_ext, b_ext, abs_a, abs_b, min_ext, a_w, spec_res;
  logic             neg_a, neg_b, div_zero, ovf;

  assign a_sw    = {{HW{io.dividend[HW-1]}}, io.dividend[HW-1:0]};
  assign b_sw    = {{HW{io.divisor[HW-1]}}, io.divisor[HW-1:0]};
  assign a_ext   = io.div_w ? (io.div_u ? {{HW{1'b0}}, io.dividend[HW-1:0]} : a_sw) : io.dividend;
  assign b_ext   = io.div_w ? (io.div_u ? {{HW{1'b0}}, io.divisor[HW-1:0]} : b_sw) : io.divisor;
  assign neg_a   = ~io.div_u & a_ext[WIDTH-1];
  assign neg_b   = ~io.div_u & b_ext[WIDTH-1];
  assign abs_a   = neg_a ? -a_ext : a_ext;
  assign abs_b   = neg_b ? -b_ext : b_ext;
  assign min_ext = io.div_w ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(WIDTH-1){1'b0}}};
  assign div_zero = (b_ext == '0);
  assign ovf      = ~io.div_u & (b_ext == '1) & (a_ext == min_ext);
  assign a_w      = io.div_w ? a_sw : io.dividend;
  // Divide-by-zero: q=-1, r=dividend. Overflow: q=dividend, r=0.
  assign spec_res = io.div_rem ? (div_zero ? a_w : '0) : (div_zero ? '1 : a_w);

  // One restoring step on the magnitudes.
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_n, quo_n, q_fin, r_fin, sel, calc_res;
  logic             last;

  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, dvs_q});
  assign rem_n    = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
  assign quo_n    = {quo_q[WIDTH-2:0], ge};
  assign q_fin    = q_neg_q ? -quo_n : quo_n;
  assign r_fin    = r_neg_q ? -rem_n : rem_n;
  assign sel      = is_rem_q ? r_fin : q_fin;
  assign calc_res = is_w_q ? {{HW{sel[HW-1]}}, sel[HW-1:0]} : sel;
  assign last     = (cnt_q == (is_w_q ? CW'(HW - 1) : CW'(WIDTH - 1)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    result_d    = result_q;
    is_rem_d    = is_rem_q;
    is_w_d      = is_w_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (io.div_valid) begin
          is_rem_d = io.div_rem;
          is_w_d   = io.div_w;
          q_neg_d  = neg_a ^ neg_b;
          r_neg_d  = neg_a;
          dvs_d    = abs_b;
          rem_d    = '0;
          // Word dividends sit in the upper half so 32 shifts consume them.
          quo_d    = io.div_w ? (abs_a << HW) : abs_a;
          cnt_d    = '0;
          busy_d   = 1'b1;
          if (div_zero || ovf) begin
            state_d     = DONE;
            result_d    = spec_res;
            out_valid_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!io.div_valid) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            state_d     = DONE;
            result_d    = calc_res;
            out_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (io.flush) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      result_q    <= '0;
      is_rem_q    <= 1'b0;
      is_w_q      <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      result_q    <= result_d;
      is_rem_q    <= is_rem_d;
      is_w_q      <= is_w_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // A flush landing on the done cycle suppresses the pulse that cycle.
  assign io.out_valid = out_valid_q & ~io.flush;
  assign io.result    = result_q;
  assign io.busy      = busy_q;
endmodule

// File: tb/tb_ysyx_22041752_div.sv
// Bench for ysyx_22041752_div: directed vector table, randomised ops against a reference model,
// and hand sequences for flush, abort and mid-operation reset.
module tb_ysyx_22041752_div;
  logic clk;
  logic reset;
  int   chk;
  int   err;

  ysyx_22041752_div_if #(.WIDTH(64)) io ();

  ysyx_22041752_div #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [63:0] q_exp[$];
  int          q_lat[$];

  typedef struct {
    logic        u;
    logic        w;
    logic        r;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
    int          lat;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic u, input logic w, input logic r,
                                          input logic [63:0] a, input logic [63:0] b);
    logic        [31:0] a32, b32, r32;
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa, sb;
    logic        [63:0] r64;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0)                                     r32 = r ? a32 : 32'hFFFF_FFFF;
      else if (u)                                           r32 = r ? (a32 % b32) : (a32 / b32);
      else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = r ? 32'd0 : a32;
      else begin
        sa32 = a32;
        sb32 = b32;
        if (r) r32 = sa32 % sb32;
        else   r32 = sa32 / sb32;
      end
      r64 = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0)                                        r64 = r ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (u)                                            r64 = r ? (a % b) : (a / b);
      else if (a == 64'h8000_0000_0000_0000 && b == '1)      r64 = r ? 64'd0 : a;
      else begin
        sa = a;
        sb = b;
        if (r) r64 = sa % sb;
        else   r64 = sa / sb;
      end
    end
    return r64;
  endfunction

  function automatic int ref_lat(input logic u, input logic w, input logic [63:0] a, input logic [63:0] b);
    if (w) begin
      if (b[31:0] == 32'd0 || (!u && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) return 1;
      return 33;
    end
    if (b == 64'd0 || (!u && a == 64'h8000_0000_0000_0000 && b == '1)) return 1;
    return 65;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = 64'd1;
      2:       v = '1;
      3:       v = 64'h8000_0000_0000_0000;
      4:       v = 64'h0000_0000_8000_0000;
      5:       v = {$urandom(), $urandom()};
      6:       v = 64'($urandom_range(0, 40)) - 64'd20;
      default: v = {$urandom(), $urandom()} >> $urandom_range(0, 63);
    endcase
    return v;
  endfunction

  // Called at posedge+1; that cycle is cycle 0 of the request.
  task automatic issue(input logic u, input logic w, input logic r, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat,
                       input bit hold, input string name);
    int          cyc;
    bit          got;
    logic [63:0] e;
    int          l;
    io.div_u     = u;
    io.div_w     = w;
    io.div_rem   = r;
    io.dividend  = a;
    io.divisor   = b;
    io.div_valid = 1'b1;
    q_exp.push_back(exp);
    q_lat.push_back(lat);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc <= 200) begin
      @(negedge clk);
      if (io.out_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    e = q_exp.pop_front();
    l = q_lat.pop_front();
    if (!got) begin
      chk++;
      err++;
      $display("FAIL %s timeout: no out_valid within %0d cycles, expected result %h", name, cyc, e);
    end else begin
      check({name, " result"}, io.result, e);
      check({name, " latency"}, 64'(cyc), 64'(l));
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      io.div_valid = 1'b0;
      @(negedge clk);
      check({name, " pulse"}, {63'd0, io.out_valid}, 64'd0);
      check({name, " idle busy"}, {63'd0, io.busy}, 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int          spurious;
    logic        ru, rw, rr;
    logic [63:0] ra, rb;
    chk = 0;
    err = 0;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 64'h0000_0001_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 64'd7, 64'h1234_5678_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 65};

    reset        = 1'b1;
    io.flush     = 1'b0;
    io.div_valid = 1'b0;
    io.div_u     = 1'b0;
    io.div_w     = 1'b0;
    io.div_rem   = 1'b0;
    io.dividend  = '0;
    io.divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", {63'd0, io.out_valid}, 64'd0);
    check("reset busy", {63'd0, io.busy}, 64'd0);
    check("reset result", io.result, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Table runs back-to-back: valid stays high across each done pulse.
    for (int i = 0; i < 13; i++)
      issue(tbl[i].u, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].e, tbl[i].lat,
            (i != 12), $sformatf("tbl%0d", i));

    // Flush in cycle 20 of a 64-bit DIV, then a fresh DIVU.
    io.div_u = 1'b0; io.div_w = 1'b0; io.div_rem = 1'b0;
    io.dividend = 64'd1000; io.divisor = 64'd3; io.div_valid = 1'b1;
    spurious = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (io.out_valid) spurious++;
      @(posedge clk);
      #1;
    end
    io.flush = 1'b1;
    @(negedge clk);
    if (io.out_valid) spurious++;
    @(posedge clk);
    #1;
    io.flush = 1'b0;
    io.div_valid = 1'b0;
    @(negedge clk);
    if (io.out_valid) spurious++;
    check("flush no out_valid", 64'(spurious), 64'd0);
    check("flush busy cycle21", {63'd0, io.busy}, 64'd0);
    @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 65, 1'b0, "divu after flush");

    // Flush on the done cycle of a divide-by-zero suppresses the pulse.
    io.div_u = 1'b0; io.div_w = 1'b0; io.div_rem = 1'b0;
    io.dividend = 64'd5; io.divisor = 64'd0; io.div_valid = 1'b1;
    @(posedge clk);
    #1;
    io.flush = 1'b1;
    @(negedge clk);
    check("flush on done", {63'd0, io.out_valid}, 64'd0);
    @(posedge clk);
    #1;
    io.flush = 1'b0;
    io.div_valid = 1'b0;
    @(negedge clk);
    check("after flush on done out_valid", {63'd0, io.out_valid}, 64'd0);
    check("after flush on done busy", {63'd0, io.busy}, 64'd0);

    // Flush beats a new request in IDLE.
    @(posedge clk);
    #1;
    io.flush = 1'b1;
    io.dividend = 64'd9; io.divisor = 64'd3; io.div_valid = 1'b1;
    @(posedge clk);
    #1;
    io.flush = 1'b0;
    io.div_valid = 1'b0;
    @(negedge clk);
    check("flush beats request busy", {63'd0, io.busy}, 64'd0);

    // Valid dropped mid-CALC aborts without a pulse.
    @(posedge clk);
    #1;
    io.dividend = 64'd12345; io.divisor = 64'd11; io.div_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    io.div_valid = 1'b0;
    spurious = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (io.out_valid) spurious++;
    end
    check("abort no out_valid", 64'(spurious), 64'd0);
    check("abort busy", {63'd0, io.busy}, 64'd0);

    // Reset asserted mid-CALC.
    @(posedge clk);
    #1;
    io.dividend = 64'd777; io.divisor = 64'd5; io.div_valid = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    io.div_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midreset out_valid", {63'd0, io.out_valid}, 64'd0);
    check("midreset busy", {63'd0, io.busy}, 64'd0);
    check("midreset result", io.result, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    spurious = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (io.out_valid) spurious++;
    end
    check("after reset no out_valid", 64'(spurious), 64'd0);
    @(posedge clk);
    #1;

    // Random mix, some back-to-back.
    for (int i = 0; i < 40; i++) begin
      ru = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      ra = pick();
      rb = pick();
      issue(ru, rw, rr, ra, rb, ref_res(ru, rw, rr, ra, rb), ref_lat(ru, rw, ra, rb),
            (i != 39) && ($urandom_range(0, 1) == 1), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
